// File: rtl/regfile_2r1w.sv
// rtl/regfile_2r1w.sv - 2-read/1-write register file with valid flags, bypass and sequential clear
module regfile_2r1w #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    input  logic              rd0_en,
    input  logic [ADDR_W-1:0] rd0_addr,
    output logic [DATA_W-1:0] rd0_data,
    output logic              rd0_valid,
    input  logic              rd1_en,
    input  logic [ADDR_W-1:0] rd1_addr,
    output logic [DATA_W-1:0] rd1_data,
    output logic              rd1_valid,
    input  logic              clr_req,
    output logic              busy
);

    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  vld;
    logic              wr_accept;
    logic              clr_start;
    logic              clr_done;

    // clr_req sampled in IDLE takes priority over a write in the same cycle
    assign clr_start = (state == IDLE) && clr_req;
    assign clr_done  = (state == CLEAR) && (ptr == LAST);
    assign wr_accept = wr_en && (state == IDLE) && !clr_req && ({1'b0, wr_addr} < DEPTH_C);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (clr_req)  state_nxt = CLEAR;
            CLEAR:   if (clr_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == CLEAR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                            ptr <= '0;
        else if (clr_start)                 ptr <= '0;
        else if (state == CLEAR && !clr_done) ptr <= ptr + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            vld <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (state == CLEAR && ptr == ADDR_W'(i)) begin
                    mem[i] <= '0;
                    vld[i] <= 1'b0;
                end else if (wr_accept && wr_addr == ADDR_W'(i)) begin
                    mem[i] <= wr_data;
                    vld[i] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) wr_ack <= 1'b0;
        else     wr_ack <= wr_accept;
    end

    logic              rd_en   [2];
    logic [ADDR_W-1:0] rd_addr [2];
    logic [DATA_W-1:0] rd_data [2];
    logic              rd_vld  [2];

    assign rd_en[0]   = rd0_en;
    assign rd_en[1]   = rd1_en;
    assign rd_addr[0] = rd0_addr;
    assign rd_addr[1] = rd1_addr;
    assign rd0_data   = rd_data[0];
    assign rd0_valid  = rd_vld[0];
    assign rd1_data   = rd_data[1];
    assign rd1_valid  = rd_vld[1];

    for (genvar p = 0; p < 2; p++) begin : g_rd
        logic [DATA_W-1:0] lk_data;
        logic              lk_vld;

        // write-first: an accepted write to the same address is forwarded
        always_comb begin
            lk_data = '0;
            lk_vld  = 1'b0;
            if (state == IDLE && {1'b0, rd_addr[p]} < DEPTH_C) begin
                if (wr_accept && rd_addr[p] == wr_addr) begin
                    lk_data = wr_data;
                    lk_vld  = 1'b1;
                end else begin
                    for (int i = 0; i < DEPTH; i++) begin
                        if (rd_addr[p] == ADDR_W'(i)) begin
                            lk_data = mem[i];
                            lk_vld  = vld[i];
                        end
                    end
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rd_data[p] <= '0;
                rd_vld[p]  <= 1'b0;
            end else if (rd_en[p]) begin
                rd_data[p] <= lk_data;
                rd_vld[p]  <= lk_vld;
            end
        end
    end

endmodule
